// File: rtl/wb_pkg.sv
// Shared encodings for the write-back stage: result-source select, load size, FSM state.
package wb_pkg;

  localparam logic [1:0] WB_SEL_ALU  = 2'b00;
  localparam logic [1:0] WB_SEL_MEM  = 2'b01;
  localparam logic [1:0] WB_SEL_LINK = 2'b10;

  localparam logic [1:0] LD_B = 2'b00;
  localparam logic [1:0] LD_H = 2'b01;
  localparam logic [1:0] LD_W = 2'b10;
  localparam logic [1:0] LD_X = 2'b11;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    HOLD   = 2'b01,
    COMMIT = 2'b10
  } wb_state_e;

endpackage

// File: rtl/wb_load_align.sv
// Combinational sub-word load lane select and sign/zero extension (little-endian lanes).
module wb_load_align
  import wb_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0]            rdata,
  input  logic [1:0]                 size,
  input  logic                       uns,
  input  logic [$clog2(XLEN/8)-1:0]  lo,
  output logic [XLEN-1:0]            data
);

  localparam int LO_W = $clog2(XLEN/8);

  logic [LO_W-1:0] lo_al;
  logic [XLEN-1:0] sh;

  always_comb begin
    // Round the byte offset down to the access size before shifting the lane to bit 0.
    lo_al = lo;
    case (size)
      LD_H:    lo_al[0]   = 1'b0;
      LD_W:    lo_al[1:0] = 2'b00;
      LD_X:    lo_al      = '0;
      default: ;
    endcase
    sh = rdata >> {lo_al, 3'b000};
    case (size)
      LD_B:    data = uns ? XLEN'(sh[7:0])  : XLEN'($signed(sh[7:0]));
      LD_H:    data = uns ? XLEN'(sh[15:0]) : XLEN'($signed(sh[15:0]));
      LD_W:    data = uns ? XLEN'(sh[31:0]) : XLEN'($signed(sh[31:0]));
      default: data = sh;
    endcase
  end

endmodule

// File: rtl/wb_stage.sv
// MIPS write-back stage: handshake intake, late-load wait, one registered RF write per instruction.
// Define WB_LOAD_EXT_EN to enable sub-word load alignment/extension; otherwise load data passes raw.
module wb_stage
  import wb_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic                       in_reg_write,
  input  logic [REG_ADDR_W-1:0]      in_rd,
  input  logic [1:0]                 in_wb_sel,
  input  logic [XLEN-1:0]            in_alu_result,
  input  logic [XLEN-1:0]            in_link_addr,
  input  logic [1:0]                 in_load_size,
  input  logic                       in_load_unsigned,
  input  logic [$clog2(XLEN/8)-1:0]  in_addr_lo,
  input  logic                       mem_rvalid,
  input  logic [XLEN-1:0]            mem_rdata,
  output logic                       rf_we,
  output logic [REG_ADDR_W-1:0]      rf_waddr,
  output logic [XLEN-1:0]            rf_wdata,
  output logic                       fwd_valid,
  output logic [REG_ADDR_W-1:0]      fwd_rd,
  output logic [XLEN-1:0]            fwd_data
);

  wb_state_e               state_q, state_d;
  logic                    rdy_q;
  logic                    accept, commit_go, from_hold;
  logic                    hold_we;
  logic [REG_ADDR_W-1:0]   hold_rd;
  logic                    we_d;
  logic [REG_ADDR_W-1:0]   waddr_d;
  logic [XLEN-1:0]         wdata_d, ld_data;

  // rdy_q keeps in_ready low through reset and for the first edge after it.
  assign in_ready = rdy_q && (state_q != HOLD);
  assign accept   = in_valid && in_ready;

`ifdef WB_LOAD_EXT_EN
  logic [1:0]                hold_size, ld_size;
  logic                      hold_uns, ld_uns;
  logic [$clog2(XLEN/8)-1:0] hold_lo, ld_lo;

  assign ld_size = from_hold ? hold_size : in_load_size;
  assign ld_uns  = from_hold ? hold_uns  : in_load_unsigned;
  assign ld_lo   = from_hold ? hold_lo   : in_addr_lo;

  wb_load_align #(.XLEN(XLEN)) u_align (
    .rdata (mem_rdata),
    .size  (ld_size),
    .uns   (ld_uns),
    .lo    (ld_lo),
    .data  (ld_data)
  );

  always_ff @(posedge clk) begin
    if (accept) begin
      hold_size <= in_load_size;
      hold_uns  <= in_load_unsigned;
      hold_lo   <= in_addr_lo;
    end
  end
`else
  logic unused_ld;
  assign unused_ld = ^{in_load_size, in_load_unsigned, in_addr_lo};
  assign ld_data   = mem_rdata;
`endif

  always_comb begin
    state_d   = state_q;
    commit_go = 1'b0;
    from_hold = 1'b0;
    case (state_q)
      HOLD: begin
        if (mem_rvalid) begin
          state_d   = COMMIT;
          commit_go = 1'b1;
          from_hold = 1'b1;
        end
      end
      default: begin
        if (accept) begin
          if (in_wb_sel == WB_SEL_MEM && !mem_rvalid) begin
            state_d = HOLD;
          end else begin
            state_d   = COMMIT;
            commit_go = 1'b1;
          end
        end else begin
          state_d = IDLE;
        end
      end
    endcase
  end

  always_comb begin
    we_d    = from_hold ? hold_we : in_reg_write;
    waddr_d = from_hold ? hold_rd : in_rd;
    if (from_hold || in_wb_sel == WB_SEL_MEM) begin
      wdata_d = ld_data;
    end else if (in_wb_sel == WB_SEL_LINK) begin
      wdata_d = in_link_addr;
    end else begin
      wdata_d = in_alu_result;
    end
  end

  // Stage boundary: accepted instruction fields parked while a load waits.
  always_ff @(posedge clk) begin
    if (accept) begin
      hold_we <= in_reg_write;
      hold_rd <= in_rd;
    end
  end

  // Stage boundary: registered register-file write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rdy_q    <= 1'b0;
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else begin
      state_q <= state_d;
      rdy_q   <= 1'b1;
      rf_we   <= commit_go && we_d && (waddr_d != '0);
      if (commit_go) begin
        rf_waddr <= waddr_d;
        rf_wdata <= wdata_d;
      end
    end
  end

  assign fwd_valid = rf_we;
  assign fwd_rd    = rf_waddr;
  assign fwd_data  = rf_wdata;

endmodule

// File: doc/wb_stage.md
# wb_stage

Write-back stage for the pipelined MIPS core, generalised in data width and extended with real sequencing. Accepts instructions from the MEM stage over a valid/ready handshake, waits for late load data from the data memory, aligns and sign/zero-extends sub-word loads, and commits one register-file write per instruction. It also drives a bypass port toward the forwarding unit. It sits between the MEM/WB boundary and the register file write port.

## Interface
- XLEN, 32: datapath width; 32 or 64 only.
- REG_ADDR_W, 5: register address width.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  MEM stage offers an instruction.
- in_ready  out  1  stage can accept; low only in HOLD.
- in_reg_write  in  1  instruction writes a register.
- in_rd  in  REG_ADDR_W  destination register.
- in_wb_sel  in  2  result source: 00 ALU, 01 MEM, 10 LINK, 11 treated as ALU.
- in_alu_result  in  XLEN  ALU result.
- in_link_addr  in  XLEN  return address for JAL/JALR.
- in_load_size  in  2  00 byte, 01 half, 10 word, 11 full XLEN.
- in_load_unsigned  in  1  zero-extend instead of sign-extend.
- in_addr_lo  in  log2(XLEN/8)  low bits of the load address.
- mem_rvalid  in  1  load data valid this cycle.
- mem_rdata  in  XLEN  raw load data, little-endian lanes.
- rf_we / rf_waddr / rf_wdata  out  1 / REG_ADDR_W / XLEN  register-file write port.
- fwd_valid / fwd_rd / fwd_data  out  1 / REG_ADDR_W / XLEN  bypass, mirrors the rf_* outputs.

## Operation
- States:
  - IDLE: empty.
  - HOLD: load accepted, data not yet received.
  - COMMIT: write presented on rf_*.
- Acceptance: a transfer occurs when in_valid && in_ready. All in_* fields are latched on that edge.
- Transitions on acceptance:
  - wb_sel ≠ MEM goes to COMMIT.
  - wb_sel = MEM with mem_rvalid in the same cycle latches mem_rdata and goes to COMMIT.
  - wb_sel = MEM without mem_rvalid goes to HOLD.
- HOLD:
  - in_ready = 0.
  - mem_rvalid latches mem_rdata and goes to COMMIT. Otherwise the stage stays in HOLD indefinitely.
- COMMIT:
  - rf_we = latched reg_write && rd ≠ 0.
  - A new acceptance in the same cycle follows the acceptance rules. Otherwise the stage returns to IDLE.
- rd = 0: rf_we and fwd_valid stay low. The $zero register is never written.
- mem_rvalid outside HOLD, or not coinciding with a MEM-source acceptance, is ignored.
- Load alignment:
  - Selected lane = in_addr_lo, rounded down to the access size.
  - Word and full loads ignore the low bits they do not need.
  - Extension is signed unless in_load_unsigned is set.
  - With XLEN=32, size 10 equals size 11.

## Timing
- Reset: all outputs 0; state IDLE; in_ready = 1 one cycle after deassertion.
- Latency, non-load or load with data at accept: accept edge N, rf_we high during cycle N+1 for exactly one cycle.
- Latency, load with data k cycles after accept: rf_we in the cycle after mem_rvalid.
- Throughput: one instruction per cycle when no load waits.
- fwd_* are identical to rf_* in the same cycle.
- Reset asserted mid-HOLD or mid-COMMIT: the pending instruction is dropped and no write is issued.
- rf_wdata is registered; no combinational path from in_* to rf_*.

## Configuration
- WB_LOAD_EXT_EN defined: byte/half/word extraction and extension as above.
- WB_LOAD_EXT_EN undefined: mem_rdata passes through unmodified. in_load_size, in_load_unsigned and in_addr_lo are ignored; the latter is left unconnected internally.

## Structure
- wb_pkg holds:
  - wb_sel encodings (WB_SEL_ALU, WB_SEL_MEM, WB_SEL_LINK);
  - load-size encodings (LD_B, LD_H, LD_W, LD_X);
  - the state encoding (IDLE, HOLD, COMMIT).
- One sub-module, wb_load_align: combinational lane select plus extension, parameterised by XLEN. It is instantiated only under WB_LOAD_EXT_EN.

## Test plan
- ALU op, rd=8, alu=0x1234_5678 accepted at edge N → rf_we=1, waddr=8, wdata=0x1234_5678 during N+1 only.
- LB, addr_lo=2, mem_rdata=0x00_80_00_00 arriving 3 cycles after accept → in_ready low for 3 cycles; wdata=0xFFFF_FF80 the cycle after rvalid.
- LHU, addr_lo=2, mem_rdata=0x8001_0000, rvalid at accept → wdata=0x0000_8001 next cycle.
- JAL, link=0x0040_0008, rd=31 → wdata=0x0040_0008; second ALU op to rd=0 back-to-back → no rf_we, fwd_valid=0.
- Load in HOLD, rst_n pulsed low → outputs 0, no write ever issued for that load; stray mem_rvalid afterward ignored.
- Back-to-back ALU ops every cycle for 10 cycles → 10 consecutive rf_we pulses, in_ready constantly high.
